// File: rtl/wall_pkg.sv
// Shared types and constants for the wall scroller and its per-slot sub-module.
package wall_pkg;

  localparam int COORD_W      = 8;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_WALL_W   = 8;
  localparam int DEF_BIRD_X   = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    REQ  = 2'd2
  } state_t;

  function automatic logic [COORD_W-1:0] clamp_height(input logic [COORD_W-1:0] h,
                                                      input logic [COORD_W-1:0] lim);
    clamp_height = (h > lim) ? lim : h;
  endfunction

endpackage

// File: rtl/wall_slot.sv
// One wall slot: x/h/active registers, per-frame move with retirement, and
// combinational pass detection against the bird column.
module wall_slot
  import wall_pkg::*;
#(
  parameter int WALL_W = DEF_WALL_W,
  parameter int BIRD_X = DEF_BIRD_X
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_h,
  input  logic [COORD_W-1:0] speed,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] h,
  output logic               active,
  output logic [COORD_W-1:0] x_nxt,
  output logic               active_nxt,
  output logic               pass
);

  localparam logic [COORD_W:0] WALL_W_E = WALL_W[COORD_W:0];
  localparam logic [COORD_W:0] BIRD_X_E = BIRD_X[COORD_W:0];

  logic [COORD_W-1:0] x_r, h_r;
  logic               active_r;

  // Moved position, retirement and pass detection for the current MOVE cycle.
  // Walls within one width of the left edge retire before any subtraction,
  // so x never wraps below zero.
  always_comb begin
    x_nxt      = x_r;
    active_nxt = active_r;
    pass       = 1'b0;
    if (move && active_r) begin
      if ({1'b0, x_r} <= WALL_W_E) begin
        x_nxt      = '0;
        active_nxt = 1'b0;
      end else begin
        x_nxt = x_r - speed;
        pass  = (({1'b0, x_r} + WALL_W_E) > BIRD_X_E) &&
                (({1'b0, x_nxt} + WALL_W_E) <= BIRD_X_E);
      end
    end else begin
      pass = 1'b0;
    end
  end

  // Slot registers: spawn load, per-frame move/retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r      <= '0;
      h_r      <= '0;
      active_r <= 1'b0;
    end else if (load) begin
      x_r      <= load_x;
      h_r      <= load_h;
      active_r <= 1'b1;
    end else if (move) begin
      x_r      <= x_nxt;
      h_r      <= active_nxt ? h_r : '0;
      active_r <= active_nxt;
    end
  end

  assign x      = x_r;
  assign h      = h_r;
  assign active = active_r;

endmodule

// File: rtl/wall_scroller.sv
// Wall scroller top: IDLE/MOVE/REQ FSM, spawn slot select, score and speed.
// Optional speed-up is enabled by defining WALL_SCROLLER_SPEEDUP_EN.
module wall_scroller
  import wall_pkg::*;
#(
  parameter int NUM_WALLS  = 2,
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int WALL_W     = DEF_WALL_W,
  parameter int SPACING    = 80,
  parameter int BIRD_X     = DEF_BIRD_X,
  parameter int MAX_HEIGHT = 100,
  parameter int MAX_SPEED  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         frame_tick,
  input  logic [7:0]                   height_in,
  input  logic                         height_valid,
  output logic                         height_req,
  output logic [COORD_W*NUM_WALLS-1:0] wall_x,
  output logic [COORD_W*NUM_WALLS-1:0] wall_h,
  output logic [NUM_WALLS-1:0]         wall_active,
  output logic                         pass_pulse,
  output logic [7:0]                   score,
  output logic                         busy
);

  localparam logic [COORD_W-1:0] SPAWN_X     = SCREEN_W[COORD_W-1:0];
  localparam logic [COORD_W-1:0] SPAWN_LIMIT = COORD_W'(SCREEN_W - SPACING);
  localparam logic [COORD_W-1:0] H_LIMIT     = MAX_HEIGHT[COORD_W-1:0];
  // Speed never exceeds its ceiling, even in the fixed-speed build.
  localparam logic [COORD_W-1:0] BASE_SPEED  = (MAX_SPEED >= 1) ? 8'd1 : MAX_SPEED[COORD_W-1:0];

  state_t             state_r, state_nxt_s;
  logic               req_r, busy_r, pass_r;
  logic [7:0]         score_r;
  logic [COORD_W-1:0] speed_s;
  logic [COORD_W-1:0] x_nxt_s [NUM_WALLS];
  logic [NUM_WALLS-1:0] act_nxt_s, pass_s, load_s;
  logic               free_s, any_act_s, found_s, do_load_s, move_s;
  logic [COORD_W-1:0] max_x_s;

  assign move_s    = (state_r == MOVE);
  assign do_load_s = (state_r == REQ) && height_valid;

  for (genvar i = 0; i < NUM_WALLS; i++) begin : g_slot
    wall_slot #(.WALL_W(WALL_W), .BIRD_X(BIRD_X)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .move       (move_s),
      .load       (load_s[i]),
      .load_x     (SPAWN_X),
      .load_h     (clamp_height(height_in, H_LIMIT)),
      .speed      (speed_s),
      .x          (wall_x[COORD_W*i +: COORD_W]),
      .h          (wall_h[COORD_W*i +: COORD_W]),
      .active     (wall_active[i]),
      .x_nxt      (x_nxt_s[i]),
      .active_nxt (act_nxt_s[i]),
      .pass       (pass_s[i])
    );
  end

  // Spacing survey on post-move positions, lowest-free-slot select, next state.
  always_comb begin
    free_s    = 1'b0;
    any_act_s = 1'b0;
    max_x_s   = '0;
    found_s   = 1'b0;
    load_s    = '0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      free_s    = free_s | ~act_nxt_s[i];
      any_act_s = any_act_s | act_nxt_s[i];
      if (act_nxt_s[i] && (x_nxt_s[i] > max_x_s)) begin
        max_x_s = x_nxt_s[i];
      end else begin
        max_x_s = max_x_s;
      end
      load_s[i] = do_load_s && !wall_active[i] && !found_s;
      found_s   = found_s | ~wall_active[i];
    end
    state_nxt_s = state_r;
    case (state_r)
      IDLE: state_nxt_s = (frame_tick && enable) ? MOVE : IDLE;
      MOVE: state_nxt_s = (free_s && (!any_act_s || (max_x_s <= SPAWN_LIMIT))) ? REQ : IDLE;
      REQ:  state_nxt_s = height_valid ? IDLE : REQ;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= (state_nxt_s == REQ);
      busy_r  <= (state_nxt_s != IDLE);
      pass_r  <= move_s && (|pass_s);
    end
  end

`ifdef WALL_SCROLLER_SPEEDUP_EN
  logic [COORD_W-1:0] speed_r;
  assign speed_s = speed_r;
`else
  assign speed_s = BASE_SPEED;
`endif

  // Score counts at most one pass per frame; speed steps on every 8th pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_r <= 8'd0;
`ifdef WALL_SCROLLER_SPEEDUP_EN
      speed_r <= BASE_SPEED;
`endif
    end else if (move_s && (|pass_s) && (score_r != 8'hFF)) begin
      score_r <= score_r + 8'd1;
`ifdef WALL_SCROLLER_SPEEDUP_EN
      if ((score_r[2:0] == 3'b111) && (speed_r < MAX_SPEED[COORD_W-1:0])) begin
        speed_r <= speed_r + 8'd1;
      end
`endif
    end
  end

  assign height_req = req_r;
  assign busy       = busy_r;
  assign pass_pulse = pass_r;
  assign score      = score_r;

endmodule
